mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/mem_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// the controller state type and the byte-strobe patterns used for stores.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Only the five RV32 load/store sizes are memory operations.
  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Byte lanes touched by a store; halves only look at addr[1].
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = STRB_B << addr_lo;
      2'b01:   strb = STRB_H << {addr_lo[1], 1'b0};
      default: strb = STRB_W;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit sitting in the MEM stage. Turns the EX/MEM load/store into
// a single outstanding data-memory request and stalls the front of the
// pipeline until the access completes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (adds the misalign_exc output).
//
// Handshake: a request transfers on a cycle where dmem_req_valid and
// dmem_req_ready are both 1; while valid is high and ready is low every
// request field is held stable. Exactly one request is outstanding, and
// dmem_rsp_valid is only honoured while waiting for that response.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_ADDR_WIDTH     = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_read_EX_MEM_o,
  input  logic                           mem_write_EX_MEM_o,
  input  logic [2:0]                     funct3_EX_MEM_o,
  input  logic [DATA_ADDR_WIDTH-1:0]     alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]          write_data_EX_MEM_o,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
  output logic                           dmem_req_valid,
  input  logic                           dmem_req_ready,
  output logic [DATA_ADDR_WIDTH-1:0]     dmem_addr,
  output logic                           dmem_we,
  output logic [3:0]                     dmem_wstrb,
  output logic [DATA_WIDTH-1:0]          dmem_wdata,
  input  logic                           dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          dmem_rdata,
  output logic                           lsu_stall,
  output logic                           load_valid_MEM,
  output logic [DATA_WIDTH-1:0]          load_data_MEM,
  output logic [REGISTER_ADDR_WIDTH-1:0] load_rd_MEM,
  output logic [1:0]                     state_dbg
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                           misalign_exc
`endif
);

  lsu_state_e                     state_q, state_d;
  logic [DATA_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                           we_q, we_d;
  logic [3:0]                     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [2:0]                     f3_q, f3_d;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                           load_valid_q, load_valid_d;
  logic [DATA_WIDTH-1:0]          load_data_q, load_data_d;
  logic [DATA_WIDTH-1:0]          wdata_rep;
  logic [DATA_WIDTH-1:0]          aligned_data;
  logic                           mem_op;

  assign mem_op = (mem_read_EX_MEM_o | mem_write_EX_MEM_o) &
                  funct3_legal(funct3_EX_MEM_o);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  assign misaligned =
    ((funct3_EX_MEM_o[1:0] == 2'b01) && alu_res_EX_MEM_o[0]) ||
    ((funct3_EX_MEM_o[1:0] == 2'b10) && (alu_res_EX_MEM_o[1:0] != 2'b00));
  assign misalign_exc = misalign_q;
`endif

  // Replicate store data across the lanes so any strobe picks the right bytes.
  always_comb begin
    case (funct3_EX_MEM_o[1:0])
      2'b00:   wdata_rep = {4{write_data_EX_MEM_o[7:0]}};
      2'b01:   wdata_rep = {2{write_data_EX_MEM_o[15:0]}};
      default: wdata_rep = write_data_EX_MEM_o;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (aligned_data)
  );

  // Next-state and next-output logic for the access controller.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          addr_d  = alu_res_EX_MEM_o;
          we_d    = mem_write_EX_MEM_o;
          wstrb_d = store_strb(funct3_EX_MEM_o, alu_res_EX_MEM_o[1:0]);
          wdata_d = wdata_rep;
          f3_d    = funct3_EX_MEM_o;
          rd_d    = rd_EX_MEM_o;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = ST_DONE;
          if (!we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = aligned_data;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and registered outputs; reset abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= '0;
      f3_q         <= 3'b000;
      rd_q         <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_addr      = {addr_q[DATA_ADDR_WIDTH-1:2], 2'b00};
  assign dmem_we        = we_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;
  // Stall drops in DONE so EX/MEM advances exactly once per access.
  assign lsu_stall      = ((state_q == ST_IDLE) && mem_op) ||
                          (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign load_valid_MEM = load_valid_q;
  assign load_data_MEM  = load_data_q;
  assign load_rd_MEM    = rd_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a size/lane model of the memory access rules,
// a scoreboard of expected load results, and per-cycle protocol checks.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_EX_MEM_o = 1'b0;
  logic        mem_write_EX_MEM_o = 1'b0;
  logic [2:0]  funct3_EX_MEM_o = 3'b000;
  logic [31:0] alu_res_EX_MEM_o = 32'd0;
  logic [31:0] write_data_EX_MEM_o = 32'd0;
  logic [4:0]  rd_EX_MEM_o = 5'd0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        lsu_stall;
  logic        load_valid_MEM;
  logic [31:0] load_data_MEM;
  logic [4:0]  load_rd_MEM;
  logic [1:0]  state_dbg;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_exc;
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mem_lsu dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_read_EX_MEM_o   (mem_read_EX_MEM_o),
    .mem_write_EX_MEM_o  (mem_write_EX_MEM_o),
    .funct3_EX_MEM_o     (funct3_EX_MEM_o),
    .alu_res_EX_MEM_o    (alu_res_EX_MEM_o),
    .write_data_EX_MEM_o (write_data_EX_MEM_o),
    .rd_EX_MEM_o         (rd_EX_MEM_o),
    .dmem_req_valid      (dmem_req_valid),
    .dmem_req_ready      (dmem_req_ready),
    .dmem_addr           (dmem_addr),
    .dmem_we             (dmem_we),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_wdata          (dmem_wdata),
    .dmem_rsp_valid      (dmem_rsp_valid),
    .dmem_rdata          (dmem_rdata),
    .lsu_stall           (lsu_stall),
    .load_valid_MEM      (load_valid_MEM),
    .load_data_MEM       (load_data_MEM),
    .load_rd_MEM         (load_rd_MEM),
    .state_dbg           (state_dbg)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_exc        (misalign_exc)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Lowest byte lane of the access inside its word.
  function automatic int m_offset(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    if (sz == 4) return 0;
    return ((a % 4) / sz) * sz;
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a);
    return TRAP_EN && ((a % m_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << m_size(f3)) - 1) << m_offset(f3, a);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (m_size(f3) == 1) return (wd % 256) * 32'h01010101;
    if (m_size(f3) == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                         input logic [31:0] a, input logic [2:0] f3);
    int bits;
    logic [31:0] v, mask;
    bits = 8 * m_size(f3);
    v = rdata >> (8 * m_offset(f3, a));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- current op + captures ----------------
  logic [2:0]  cur_f3 = 3'b000;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] cur_wdata = 32'd0;
  logic        cur_wr = 1'b0;
  logic [31:0] cap_addr, cap_wdata, cap_load;
  logic [3:0]  cap_strb;
  logic        cap_we;
  logic [4:0]  cap_rd;
  int          done_cyc;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_req_valid) begin
        chk("req_addr", dmem_addr, (cur_addr / 4) * 4);
        chk("req_we", 32'(dmem_we), 32'(cur_wr));
        if (cur_wr) begin
          chk("req_wstrb", 32'(dmem_wstrb), 32'(m_strb(cur_f3, cur_addr)));
          chk("req_wdata", dmem_wdata, m_wdata(cur_f3, cur_wdata));
        end
      end
      if (load_valid_MEM) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load_valid", 32'd1, 32'd0);
        end else begin
          chk("load_data", load_data_MEM, exp_q.pop_front());
          chk("load_rd", 32'(load_rd_MEM), 32'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [31:0] rdat, input logic [4:0] rd_idx,
                        input int ready_wait, input int rsp_wait, input bit spurious);
    bit trap, is_load, accepted, responded, finished;
    int cyc, req_cycles, wait_cycles;
    trap = m_trap(f3, addr);
    is_load = rd_i && !wr_i;
    accepted = 0; responded = 0; finished = 0;
    req_cycles = 0; wait_cycles = 0;
    @(negedge clk);
    cur_f3 = f3; cur_addr = addr; cur_wdata = wdat; cur_wr = wr_i;
    if (is_load && !trap) begin
      exp_q.push_back(m_load(rdat, addr, f3));
      exp_rd_q.push_back(rd_idx);
    end
    mem_read_EX_MEM_o = rd_i;
    mem_write_EX_MEM_o = wr_i;
    funct3_EX_MEM_o = f3;
    alu_res_EX_MEM_o = addr;
    write_data_EX_MEM_o = wdat;
    rd_EX_MEM_o = rd_idx;
    cyc = 1;
    #1;
    chk("idle_stall", 32'(lsu_stall), 32'd1);
    chk("idle_req_valid", 32'(dmem_req_valid), 32'd0);
    while (!finished && cyc < 60) begin
      @(negedge clk);
      cyc++;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (responded || trap) begin
        chk("done_stall", 32'(lsu_stall), 32'd0);
        chk("done_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("done_load_valid", 32'(load_valid_MEM), 32'(is_load && !trap));
`ifdef LSU_MISALIGN_TRAP_EN
        chk("done_misalign", 32'(misalign_exc), 32'(trap));
`endif
        cap_load = load_data_MEM;
        cap_rd = load_rd_MEM;
        done_cyc = cyc;
        finished = 1;
        mem_read_EX_MEM_o = 1'b0;
        mem_write_EX_MEM_o = 1'b0;
      end else if (!accepted) begin
        chk("req_valid", 32'(dmem_req_valid), 32'd1);
        chk("req_stall", 32'(lsu_stall), 32'd1);
        if (req_cycles >= ready_wait) begin
          dmem_req_ready = 1'b1;
          accepted = 1;
          cap_addr = dmem_addr; cap_we = dmem_we;
          cap_strb = dmem_wstrb; cap_wdata = dmem_wdata;
        end else if (spurious) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = 32'hBAD0BAD0;
        end
        req_cycles++;
      end else begin
        chk("wait_stall", 32'(lsu_stall), 32'd1);
        chk("wait_req_valid", 32'(dmem_req_valid), 32'd0);
        if (wait_cycles >= rsp_wait) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = rdat;
          responded = 1;
        end
        wait_cycles++;
      end
    end
    if (!finished) chk("op_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] bad_f3[3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_load_valid", 32'(load_valid_MEM), 32'd0);
    chk("rst_load_data", load_data_MEM, 32'd0);
    chk("rst_load_rd", 32'(load_rd_MEM), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    rst_n = 1'b1;

    // sw, minimum latency
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 5'd0, 0, 0, 0);
    chk("sw_latency", 32'(done_cyc), 32'd4);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_strb", 32'(cap_strb), 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);

    // sb / sh lane placement
    run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 5'd0, 0, 0, 0);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_strb", 32'(cap_strb), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'd0, 5'd0, 0, 1, 0);
    chk("sh_strb", 32'(cap_strb), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);

    // loads with extension
    run_op(1'b1, 1'b0, 3'b000, 32'h202, 32'd0, 32'h12F45678, 5'd7, 0, 0, 0);
    chk("lb_data", cap_load, 32'hFFFFFFF4);
    chk("lb_rd", 32'(cap_rd), 32'd7);
    chk("lb_latency", 32'(done_cyc), 32'd4);
    run_op(1'b1, 1'b0, 3'b100, 32'h202, 32'd0, 32'h12F45678, 5'd9, 1, 0, 0);
    chk("lbu_data", cap_load, 32'h000000F4);
    run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h12F45678, 5'd3, 0, 2, 0);
    chk("lhu_data", cap_load, 32'h000012F4);
    chk("lhu_rd", 32'(cap_rd), 32'd3);
    run_op(1'b1, 1'b0, 3'b001, 32'h200, 32'd0, 32'h00008001, 5'd12, 0, 0, 0);
    chk("lh_data", cap_load, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 32'hCAFEF00D, 5'd31, 0, 0, 0);
    chk("lw_data", cap_load, 32'hCAFEF00D);

    // read and write both high: a store
    run_op(1'b1, 1'b1, 3'b010, 32'h108, 32'h0BADF00D, 32'h11111111, 5'd4, 0, 0, 0);
    chk("rw_is_store", 32'(cap_we), 32'd1);

    // ready held low, spurious response during REQ
    run_op(1'b1, 1'b0, 3'b010, 32'h208, 32'd0, 32'h55AA55AA, 5'd17, 5, 2, 1);
    chk("backpressure_latency", 32'(done_cyc), 32'd11);
    chk("backpressure_data", cap_load, 32'h55AA55AA);

    // illegal funct3: no request, no stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_read_EX_MEM_o = 1'b1;
      funct3_EX_MEM_o = bad_f3[i];
      alu_res_EX_MEM_o = 32'h500;
      #1;
      chk("illegal_stall", 32'(lsu_stall), 32'd0);
      @(negedge clk);
      chk("illegal_stall2", 32'(lsu_stall), 32'd0);
      chk("illegal_req", 32'(dmem_req_valid), 32'd0);
      mem_read_EX_MEM_o = 1'b0;
    end

    // reset while waiting for a load response
    @(negedge clk);
    cur_f3 = 3'b010; cur_addr = 32'h40C; cur_wr = 1'b0;
    mem_read_EX_MEM_o = 1'b1; funct3_EX_MEM_o = 3'b010;
    alu_res_EX_MEM_o = 32'h40C; rd_EX_MEM_o = 5'd5;
    @(negedge clk);
    chk("rstwait_req", 32'(dmem_req_valid), 32'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rstwait_stall", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0;
    mem_read_EX_MEM_o = 1'b0;
    #1;
    chk("rstwait_req_off", 32'(dmem_req_valid), 32'd0);
    chk("rstwait_stall_off", 32'(lsu_stall), 32'd0);
    chk("rstwait_load_data", load_data_MEM, 32'd0);
    chk("rstwait_load_rd", 32'(load_rd_MEM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'h77777777;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    repeat (3) begin
      chk("late_rsp_load_valid", 32'(load_valid_MEM), 32'd0);
      chk("late_rsp_stall", 32'(lsu_stall), 32'd0);
      @(negedge clk);
    end

    // misaligned word
    run_op(1'b1, 1'b0, 3'b010, 32'h301, 32'd0, 32'h89ABCDEF, 5'd8, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign_latency", 32'(done_cyc), 32'd2);
    @(negedge clk);
    chk("misalign_one_cycle", 32'(misalign_exc), 32'd0);
`else
    chk("misalign_addr", cap_addr, 32'h300);
    chk("misalign_data", cap_load, 32'h89ABCDEF);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
